// File: rtl/alu_compare_unit.sv
// Two-stage pipelined compare/select unit: EQ/NE/LT/LE/GT/GE/MIN/MAX, signed or unsigned,
// with valid/ready on both sides and a saturating count of equal-operand results.
module alu_compare_unit #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             SIGNED,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             EQ,
    output logic             LT,
    output logic             GT,
    output logic [CNT_W-1:0] match_count,
    input  logic             clr_count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             sgn;
    } req_t;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LE  = 3'b011;
    localparam logic [2:0] OP_GT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_MIN = 3'b110;
    localparam logic [2:0] OP_MAX = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    req_t             s1;
    logic             s1_valid;
    logic             advance;
    logic             accept;
    logic             eq_c, lt_c, gt_c;
    logic             bit_c;
    logic [WIDTH-1:0] c_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || advance);
    assign accept   = in_valid && in_ready;

    always_comb begin
        eq_c   = (s1.a == s1.b);
        lt_c   = s1.sgn ? ($signed(s1.a) < $signed(s1.b)) : (s1.a < s1.b);
        gt_c   = !eq_c && !lt_c;
        bit_c  = 1'b0;
        c_next = '0;
        case (s1.op)
            OP_EQ:   bit_c = eq_c;
            OP_NE:   bit_c = !eq_c;
            OP_LT:   bit_c = lt_c;
            OP_LE:   bit_c = lt_c || eq_c;
            OP_GT:   bit_c = gt_c;
            OP_GE:   bit_c = gt_c || eq_c;
            default: bit_c = 1'b0;
        endcase
        // Ties fall through to A for both MIN and MAX.
        case (s1.op)
            OP_MIN:  c_next = gt_c ? s1.b : s1.a;
            OP_MAX:  c_next = lt_c ? s1.b : s1.a;
            default: c_next = {{(WIDTH-1){1'b0}}, bit_c};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1       <= '{a: A, b: B, op: OP, sgn: SIGNED};
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            C         <= '0;
            EQ        <= 1'b0;
            LT        <= 1'b0;
            GT        <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                C  <= c_next;
                EQ <= eq_c;
                LT <= lt_c;
                GT <= gt_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (clr_count) begin
            match_count <= '0;
        end else if (out_valid && out_ready && EQ && match_count != CNT_MAX) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_compare_unit.sv
// Directed bench for alu_compare_unit (WIDTH=6, CNT_W=2 so saturation is reachable).
module tb_alu_compare_unit;

    logic       clk, rst;
    logic       in_valid, in_ready, out_valid, out_ready, clr_count;
    logic [5:0] A, B, C;
    logic [2:0] OP;
    logic       SIGNED, EQ, LT, GT;
    logic [1:0] match_count;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    alu_compare_unit #(.WIDTH(6), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .OP(OP), .SIGNED(SIGNED),
        .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .EQ(EQ), .LT(LT), .GT(GT),
        .match_count(match_count), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One transaction with no backpressure: present, check result two edges later, then drain.
    task automatic op_check(input string tag, input logic [5:0] a, input logic [5:0] b,
                            input logic [2:0] op, input logic sg, input logic [5:0] ec,
                            input logic ee, input logic el, input logic eg);
        A = a; B = b; OP = op; SIGNED = sg; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        A = 6'($urandom_range(63)); B = 6'($urandom_range(63)); OP = 3'($urandom_range(7));
        step();
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".C"}, C, ec);
        chk({tag, ".EQ"}, EQ, ee);
        chk({tag, ".LT"}, LT, el);
        chk({tag, ".GT"}, GT, eg);
        step();
        if (ee && exp_cnt != 3) exp_cnt++;
        chk({tag, ".cnt"}, match_count, exp_cnt);
        chk({tag, ".drain"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 1; clr_count = 0;
        A = 0; B = 0; OP = 0; SIGNED = 0;
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.C", C, 0);
        chk("rst.cnt", match_count, 0);
        rst = 1'b0;
        #1;
        chk("rel.in_ready", in_ready, 1);
        step();

        op_check("eq19",   6'd19, 6'd19, 3'b000, 0, 6'd1,  1, 0, 0);
        op_check("eq5_3",  6'd5,  6'd3,  3'b000, 0, 6'd0,  0, 0, 1);
        op_check("lt_s",   6'd61, 6'd2,  3'b010, 1, 6'd1,  0, 1, 0);
        op_check("lt_u",   6'd61, 6'd2,  3'b010, 0, 6'd0,  0, 0, 1);
        op_check("ge_u",   6'd61, 6'd2,  3'b101, 0, 6'd1,  0, 0, 1);
        op_check("min_s",  6'd39, 6'd60, 3'b110, 1, 6'd39, 0, 1, 0);
        op_check("max_u",  6'd39, 6'd60, 3'b111, 0, 6'd60, 0, 1, 0);
        op_check("min_tie",6'd49, 6'd49, 3'b110, 1, 6'd49, 1, 0, 0);
        op_check("le_s",   6'd63, 6'd0,  3'b011, 1, 6'd1,  0, 1, 0);
        op_check("gt_s",   6'd31, 6'd32, 3'b100, 1, 6'd1,  0, 0, 1);
        op_check("ne_eq",  6'd7,  6'd7,  3'b001, 0, 6'd0,  1, 0, 0);
        op_check("max_tie",6'd50, 6'd50, 3'b111, 0, 6'd50, 1, 0, 0);

        // Backpressure: two accepted, third stalls, then in-order drain.
        clr_count = 1; step(); clr_count = 0; exp_cnt = 0;
        chk("clr.cnt", match_count, 0);
        out_ready = 0;
        A = 1; B = 1; OP = 3'b000; SIGNED = 0; in_valid = 1;
        #1;
        chk("bp.rdy1", in_ready, 1);
        step();
        A = 2;
        chk("bp.rdy2", in_ready, 1);
        step();
        A = 3;
        chk("bp.rdy3", in_ready, 0);
        chk("bp.hold.vld", out_valid, 1);
        step(); step();
        chk("bp.stall.rdy", in_ready, 0);
        chk("bp.stall.C", C, 1);
        chk("bp.stall.EQ", EQ, 1);
        chk("bp.stall.cnt", match_count, 0);
        out_ready = 1;
        #1;
        chk("bp.rdy_open", in_ready, 1);
        step();
        in_valid = 0;
        chk("bp.r2.vld", out_valid, 1);
        chk("bp.r2.C", C, 0);
        chk("bp.r2.GT", GT, 1);
        chk("bp.r2.cnt", match_count, 1);
        step();
        chk("bp.r3.vld", out_valid, 1);
        chk("bp.r3.C", C, 0);
        chk("bp.r3.cnt", match_count, 1);
        step();
        chk("bp.end.vld", out_valid, 0);
        chk("bp.end.cnt", match_count, 1);
        exp_cnt = 1;

        // Saturation at 3 with CNT_W=2.
        clr_count = 1; step(); clr_count = 0; exp_cnt = 0;
        for (int i = 0; i < 5; i++) op_check("sat", 6'(i + 10), 6'(i + 10), 3'b000, 0, 6'd1, 1, 0, 0);
        chk("sat.final", match_count, 3);

        // Clear wins over a coincident matching transfer.
        A = 9; B = 9; OP = 3'b000; in_valid = 1; out_ready = 1;
        step(); in_valid = 0; step();
        chk("clrwin.vld", out_valid, 1);
        clr_count = 1;
        step();
        clr_count = 0;
        chk("clrwin.cnt", match_count, 0);
        chk("clrwin.vld0", out_valid, 0);
        exp_cnt = 0;

        // Reset with both stages full and output stalled.
        op_check("pre_rst", 6'd4, 6'd4, 3'b000, 0, 6'd1, 1, 0, 0);
        out_ready = 0;
        A = 4; B = 4; in_valid = 1; step();
        A = 5; step();
        in_valid = 0;
        chk("mid.vld", out_valid, 1);
        chk("mid.rdy", in_ready, 0);
        #2 rst = 1;
        #1;
        chk("arst.vld", out_valid, 0);
        chk("arst.C", C, 0);
        chk("arst.flags", {EQ, LT, GT}, 0);
        chk("arst.cnt", match_count, 0);
        chk("arst.rdy", in_ready, 0);
        step();
        #2 rst = 0;
        #1;
        chk("post.rdy", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post.no_stale", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time %0t exceeded bound 50000", $time);
        $fatal(1, "timeout");
    end

endmodule
